// File: rtl/ddc_ctrl_pkg.sv
// Shared definitions for the DDC configuration sequencer: register offsets,
// control bit positions, sequencer states and the shadow register bundle.
package ddc_ctrl_pkg;

  localparam logic [6:0] FREQ_OFS = 7'd0;
  localparam logic [6:0] RATE_OFS = 7'd1;
  localparam logic [6:0] CTRL_OFS = 7'd2;

  localparam int unsigned COMMIT_BIT = 0;
  localparam int unsigned IMMED_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_STB,
    FLUSH
  } ddc_state_t;

  typedef struct packed {
    logic [31:0] freq;
    logic [3:0]  rate2;
    logic [3:0]  rate1;
  } ddc_cfg_t;

endpackage

// File: rtl/ddc_ctrl_if.sv
// Serial settings bus as seen by the DDC channel sequencer.
interface ddc_ctrl_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (output serial_addr, serial_data, serial_strobe);
  modport slave  (input  serial_addr, serial_data, serial_strobe);
endinterface

// File: rtl/ddc_ctrl_shadow.sv
// Settings decode, shadow freq/rate registers and the pending/immediate
// commit latch feeding the ddc_ctrl sequencer.
module ddc_ctrl_shadow
  import ddc_ctrl_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR = 7'd0,
  parameter logic [3:0] DEF_RATE1 = 4'd0,
  parameter logic [3:0] DEF_RATE2 = 4'd0
) (
  input  logic             clock,
  input  logic             reset,
  ddc_ctrl_if.slave        sbus,
  input  logic             apply,
  output ddc_cfg_t         shadow,
  output logic             pending,
  output logic             immediate
);

  logic wr_freq;
  logic wr_rate;
  logic wr_commit;
  logic pend_q;
  logic imm_q;

  assign wr_freq   = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + FREQ_OFS);
  assign wr_rate   = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + RATE_OFS);
  assign wr_commit = sbus.serial_strobe && (sbus.serial_addr == BASE_ADDR + CTRL_OFS)
                     && sbus.serial_data[COMMIT_BIT];

  // A commit is visible in the cycle it is written so an immediate commit
  // lands one cycle later; an apply in that same cycle absorbs it.
  assign pending   = pend_q | wr_commit;
  assign immediate = wr_commit ? sbus.serial_data[IMMED_BIT] : imm_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow.freq  <= '0;
      shadow.rate1 <= DEF_RATE1;
      shadow.rate2 <= DEF_RATE2;
      pend_q       <= 1'b0;
      imm_q        <= 1'b0;
    end else begin
      if (wr_freq) shadow.freq <= sbus.serial_data;
      if (wr_rate) begin
        shadow.rate1 <= sbus.serial_data[3:0];
        shadow.rate2 <= sbus.serial_data[7:4];
      end
      if (wr_commit) imm_q <= sbus.serial_data[IMMED_BIT];
      if (apply)          pend_q <= 1'b0;
      else if (wr_commit) pend_q <= 1'b1;
    end
  end

endmodule

// File: rtl/ddc_ctrl.sv
// DDC channel configuration sequencer: applies shadowed freq/rate settings on
// a strobe boundary and flushes after rate changes. Optional stalled-strobe
// timeout is enabled by defining DDC_CTRL_TIMEOUT_EN.
module ddc_ctrl
  import ddc_ctrl_pkg::*;
#(
  parameter logic [6:0]  BASE_ADDR      = 7'd0,
  parameter int unsigned FLUSH_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 512,
  parameter logic [3:0]  DEF_RATE1      = 4'd0,
  parameter logic [3:0]  DEF_RATE2      = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  ddc_ctrl_if.slave   sbus,
  input  logic        master_enable,
  input  logic        ddc_strobe,
  output logic        ddc_enable,
  output logic [31:0] freq,
  output logic [3:0]  rate1,
  output logic [3:0]  rate2,
  output logic        busy,
  output logic        commit_done
);

  ddc_state_t state;
  ddc_state_t state_nxt;
  ddc_cfg_t   shadow;
  logic       pending;
  logic       immediate;
  logic       apply;
  logic       rate_chg;
  logic       timeout;
  logic       flush_last;
  logic [7:0] flush_cnt;

  ddc_ctrl_shadow #(
    .BASE_ADDR (BASE_ADDR),
    .DEF_RATE1 (DEF_RATE1),
    .DEF_RATE2 (DEF_RATE2)
  ) u_shadow (
    .clock     (clock),
    .reset     (reset),
    .sbus      (sbus),
    .apply     (apply),
    .shadow    (shadow),
    .pending   (pending),
    .immediate (immediate)
  );

`ifdef DDC_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset || state != WAIT_STB) wait_cnt <= '0;
    else                            wait_cnt <= wait_cnt + TW'(1);
  end

  assign timeout = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign rate_chg   = {shadow.rate2, shadow.rate1} != {rate2, rate1};
  assign flush_last = (flush_cnt == 8'(FLUSH_CYCLES - 1));

  // IDLE applies even while master_enable is low; elsewhere a low
  // master_enable wins over any apply so the pending commit lands in IDLE.
  always_comb begin
    apply     = 1'b0;
    state_nxt = state;
    if (state == IDLE) begin
      apply = pending;
      if (master_enable) state_nxt = RUN;
    end else if (!master_enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        RUN: begin
          if (pending && immediate) begin
            apply     = 1'b1;
            state_nxt = rate_chg ? FLUSH : RUN;
          end else if (pending) begin
            state_nxt = WAIT_STB;
          end
        end
        WAIT_STB: begin
          if (pending && (ddc_strobe || timeout)) begin
            apply     = 1'b1;
            state_nxt = rate_chg ? FLUSH : RUN;
          end
        end
        FLUSH: begin
          if (flush_last) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      freq        <= '0;
      rate1       <= DEF_RATE1;
      rate2       <= DEF_RATE2;
      ddc_enable  <= 1'b0;
      busy        <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      flush_cnt   <= (state == FLUSH && state_nxt == FLUSH) ? flush_cnt + 8'd1 : '0;
      ddc_enable  <= (state_nxt == RUN) || (state_nxt == WAIT_STB);
      busy        <= (state_nxt == WAIT_STB) || (state_nxt == FLUSH);
      commit_done <= apply;
      if (apply) begin
        freq  <= shadow.freq;
        rate1 <= shadow.rate1;
        rate2 <= shadow.rate2;
      end
    end
  end

endmodule

// File: tb/tb_ddc_ctrl.sv
// Self-checking bench for ddc_ctrl: directed scenarios plus randomized
// settings traffic, checked every cycle against a behavioural model.
module tb_ddc_ctrl;

  localparam logic [6:0] BASE  = 7'd0;
  localparam int         FLUSH = 16;
  localparam int         TMO   = 512;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        master_enable = 1'b0;
  logic        ddc_strobe = 1'b0;
  logic        ddc_enable;
  logic [31:0] freq;
  logic [3:0]  rate1;
  logic [3:0]  rate2;
  logic        busy;
  logic        commit_done;

  ddc_ctrl_if sbus ();

  ddc_ctrl #(
    .BASE_ADDR      (BASE),
    .FLUSH_CYCLES   (FLUSH),
    .TIMEOUT_CYCLES (TMO),
    .DEF_RATE1      (4'd0),
    .DEF_RATE2      (4'd0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .sbus          (sbus),
    .master_enable (master_enable),
    .ddc_strobe    (ddc_strobe),
    .ddc_enable    (ddc_enable),
    .freq          (freq),
    .rate1         (rate1),
    .rate2         (rate2),
    .busy          (busy),
    .commit_done   (commit_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int period = 0;
  bit rand_mode = 1'b0;

  // model: active/shadow settings plus channel activity described as
  // "on", "waiting for a strobe" and "flush cycles still to go"
  logic [31:0] e_freq, s_freq;
  logic [3:0]  e_r1, e_r2, s_r1, s_r2;
  bit          e_done, m_on, m_wait, m_pend, m_imm;
  int          m_flush, m_wcnt;

  int   n_done, n_low, chg_cyc;
  bit   chg_ds;
  logic [39:0] prev_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input bit rst, input logic [6:0] a, input logic [31:0] d,
                            input bit s, input bit men, input bit ds);
    bit commit, pend, imm, apply, was_on, timed;
    if (rst) begin
      e_freq = '0; s_freq = '0; e_r1 = 4'd0; e_r2 = 4'd0; s_r1 = 4'd0; s_r2 = 4'd0;
      e_done = 0; m_on = 0; m_wait = 0; m_pend = 0; m_imm = 0; m_flush = 0; m_wcnt = 0;
      return;
    end
    commit = s && (a == BASE + 7'd2) && d[0];
    pend   = m_pend || commit;
    imm    = commit ? d[1] : m_imm;
    apply  = 0;
    was_on = m_on;
    if (!m_on) begin
      apply = pend;
      m_on  = men;
    end else if (!men) begin
      m_on = 0; m_wait = 0; m_flush = 0;
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (m_wait) begin
      timed = 0;
`ifdef DDC_CTRL_TIMEOUT_EN
      m_wcnt++;
      timed = (m_wcnt == TMO);
`endif
      if (ds || timed) begin apply = 1; m_wait = 0; end
    end else if (pend) begin
      if (imm) apply = 1;
      else begin m_wait = 1; m_wcnt = 0; end
    end
    if (apply) begin
      if (was_on && ({s_r2, s_r1} != {e_r2, e_r1})) m_flush = FLUSH;
      e_freq = s_freq; e_r1 = s_r1; e_r2 = s_r2;
      pend = 0;
    end
    e_done = apply;
    if (s && a == BASE) s_freq = d;
    if (s && a == BASE + 7'd1) begin s_r1 = d[3:0]; s_r2 = d[7:4]; end
    m_pend = pend;
    m_imm  = imm;
  endtask

  task automatic tick(input logic [6:0] a, input logic [31:0] d, input bit s);
    bit ds;
    if (rand_mode) ds = ($urandom_range(0, 11) == 0);
    else           ds = (period != 0) && (cyc % period == 0);
    sbus.serial_addr   = a;
    sbus.serial_data   = d;
    sbus.serial_strobe = s;
    ddc_strobe         = ds;
    model_step(reset, a, d, s, master_enable, ds);
    @(negedge clock);
    chk("freq", freq, e_freq);
    chk("rate1", 32'(rate1), 32'(e_r1));
    chk("rate2", 32'(rate2), 32'(e_r2));
    chk("ddc_enable", 32'(ddc_enable), 32'(m_on && m_flush == 0));
    chk("busy", 32'(busy), 32'(m_on && (m_wait || m_flush > 0)));
    chk("commit_done", 32'(commit_done), 32'(e_done));
    if (commit_done) n_done++;
    if (!ddc_enable) n_low++;
    if ({freq, rate2, rate1} != prev_out) begin chg_cyc = cyc; chg_ds = ds; end
    prev_out = {freq, rate2, rate1};
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, '0, 1'b0);
  endtask

  task automatic clr_obs();
    n_done = 0; n_low = 0; chg_cyc = -1; chg_ds = 0;
  endtask

  initial begin
    int c0;
    prev_out = '0;
    clr_obs();
    // reset
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst_freq", freq, 32'h0);
    chk("rst_en", 32'(ddc_enable), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // non-immediate freq commit, no rate change
    master_enable = 1'b1;
    period = 20;
    idle(5);
    tick(BASE, 32'h1000_0000, 1'b1);
    clr_obs();
    tick(BASE + 7'd2, 32'h1, 1'b1);
    idle(40);
    chk("t1_freq", freq, 32'h1000_0000);
    chk("t1_after_strobe", 32'(chg_ds), 32'h1);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_no_flush", n_low, 0);

    // rate change applied on strobe, followed by flush
    tick(BASE + 7'd1, 32'h33, 1'b1);
    clr_obs();
    tick(BASE + 7'd2, 32'h1, 1'b1);
    idle(45);
    chk("t2_rate1", 32'(rate1), 32'h3);
    chk("t2_rate2", 32'(rate2), 32'h3);
    chk("t2_flush_len", n_low, 16);
    chk("t2_en_after", 32'(ddc_enable), 32'h1);

    // immediate commit with rate change still flushes
    tick(BASE + 7'd1, 32'h55, 1'b1);
    clr_obs();
    tick(BASE + 7'd2, 32'h3, 1'b1);
    chk("t3_rate1_now", 32'(rate1), 32'h5);
    chk("t3_done_now", 32'(commit_done), 32'h1);
    idle(30);
    chk("t3_flush_len", n_low, 16);
    chk("t3_done_pulses", n_done, 1);

    // commit coincident with strobe waits for the next strobe
    tick(BASE, 32'hABCD_0123, 1'b1);
    while (cyc % 20 != 0) idle(1);
    clr_obs();
    c0 = cyc;
    tick(BASE + 7'd2, 32'h1, 1'b1);
    idle(30);
    chk("t4_wait_len", chg_cyc - c0, 20);
    chk("t4_freq", freq, 32'hABCD_0123);

    // drop master_enable during flush, apply in IDLE, re-enable without flush
    tick(BASE + 7'd1, 32'h77, 1'b1);
    tick(BASE + 7'd2, 32'h3, 1'b1);
    idle(3);
    master_enable = 1'b0;
    tick(BASE, 32'h5, 1'b1);
    tick(BASE + 7'd2, 32'h1, 1'b1);
    idle(2);
    chk("t5_freq_idle", freq, 32'h5);
    chk("t5_en_idle", 32'(ddc_enable), 32'h0);
    master_enable = 1'b1;
    clr_obs();
    idle(30);
    chk("t5_no_flush", n_low, 0);

    // stalled strobe
    period = 0;
    tick(BASE, 32'h0BAD_F00D, 1'b1);
    clr_obs();
    tick(BASE + 7'd2, 32'h1, 1'b1);
    idle(2000);
`ifdef DDC_CTRL_TIMEOUT_EN
    chk("t6_timeout_apply", n_done, 1);
    chk("t6_not_busy", 32'(busy), 32'h0);
`else
    chk("t6_still_busy", 32'(busy), 32'h1);
    chk("t6_no_apply", n_done, 0);
`endif
    period = 20;
    idle(30);

    // randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic [6:0]  a;
      logic [31:0] d;
      bit          s;
      if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if ($urandom_range(0, 149) == 0) master_enable = ~master_enable;
      s = ($urandom_range(0, 5) == 0);
      a = BASE + 7'($urandom_range(0, 4));
      d = $urandom;
      if (a == BASE + 7'd1) d = {24'h0, 2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
      tick(a, d, s);
      reset = 1'b0;
    end
    rand_mode = 1'b0;

    // reset mid-operation clears the shadows too
    master_enable = 1'b1;
    idle(30);
    tick(BASE + 7'd1, 32'h99, 1'b1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    clr_obs();
    tick(BASE + 7'd2, 32'h3, 1'b1);
    idle(20);
    chk("t7_rate1_def", 32'(rate1), 32'h0);
    chk("t7_no_flush", n_low, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
